byteswap_stream: RTL and testbench

BYTESWAP_STREAM -- requirements
Module: byteswap_stream

---
 rtl/byteswap_pkg.sv | 47 ++++
 rtl/byteswap_skid_fifo.sv | 53 +++++
 rtl/byteswap_stream.sv | 133 +++++++++++++
 tb/tb_byteswap_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/byteswap_pkg.sv
// byteswap_pkg
// Shared types and the lane-swap helper for the byteswap stream block.
//   swap_mode_e  : PASS / SWAP32 / SWAP64 / RSVD (RSVD behaves like PASS)
//   fsm_state_e  : IDLE / RUN / DONE
//   swap_lane64(): pure function that byte-reverses one 64-bit lane according
//                  to the mode. Wider buses apply it once per 64-bit lane.
package byteswap_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    SWAP32 = 2'd1,
    SWAP64 = 2'd2,
    RSVD   = 2'd3
  } swap_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

  localparam int C_LANE_WIDTH = 64;

  function automatic logic [C_LANE_WIDTH-1:0] swap_lane64(
    input logic [C_LANE_WIDTH-1:0] lane,
    input swap_mode_e              mode
  );
    logic [C_LANE_WIDTH-1:0] res;
    res = lane;
    case (mode)
      SWAP32: begin
        for (int b = 0; b < 4; b++) begin
          res[8*b +: 8]      = lane[8*(3-b) +: 8];
          res[32+8*b +: 8]   = lane[32+8*(3-b) +: 8];
        end
      end
      SWAP64: begin
        for (int b = 0; b < 8; b++) begin
          res[8*b +: 8] = lane[8*(7-b) +: 8];
        end
      end
      default: res = lane;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/byteswap_skid_fifo.sv
// byteswap_skid_fifo
// Two-entry FIFO used as the skid buffer between the upstream and downstream
// streams. The head entry is presented combinationally from storage, so a
// push into an empty FIFO is visible on o_data the next cycle.
// The caller never pushes when full nor pops when empty.
// Ports:
//   ap_clk, areset : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data : write strobe and data
//   i_pop          : read strobe (advances the head)
//   o_data         : head entry
//   o_occupancy    : number of valid entries, 0..2
module byteswap_skid_fifo #(
  parameter int C_DATA_WIDTH = 512
) (
  input  logic                    ap_clk,
  input  logic                    areset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [C_DATA_WIDTH-1:0] i_data,
  output logic [C_DATA_WIDTH-1:0] o_data,
  output logic [1:0]              o_occupancy
);

  logic [C_DATA_WIDTH-1:0] r_mem [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge ap_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data      = r_mem[r_rd_ptr];
  assign o_occupancy = r_count;

endmodule

// File: rtl/byteswap_stream.sv
// byteswap_stream
// Streams a fixed number of beats from s_axis to m_axis, byte-swapping each
// beat per the mode latched at start. Data is swapped on entry to a 2-entry
// skid FIFO, so the output side is purely registered.
// Ports:
//   ap_clk, areset                 : clock, synchronous active-high reset
//   ctrl_start                     : one-cycle start pulse (honoured in IDLE only)
//   ctrl_xfer_size_in_bytes        : transfer length, sampled on start
//   ctrl_mode                      : 0 pass, 1 swap32, 2 swap64, 3 pass
//   ctrl_done                      : one-cycle completion pulse
//   busy                           : high in RUN and DONE
//   s_axis_tvalid/tready/tdata     : upstream stream
//   m_axis_tvalid/tready/tdata/tlast : downstream stream
//
// state | meaning
// IDLE  | waiting for ctrl_start
// RUN   | moving beats; leaves on handshake of the final output beat
// DONE  | one cycle, pulses ctrl_done
module byteswap_stream
  import byteswap_pkg::*;
#(
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  input  logic                         ctrl_start,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  input  logic [1:0]                   ctrl_mode,
  output logic                         ctrl_done,
  output logic                         busy,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]      s_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                         m_axis_tlast
);

  localparam int C_BYTES_LOG2 = $clog2(C_DATA_WIDTH / 8);
  localparam int C_NUM_LANES  = C_DATA_WIDTH / C_LANE_WIDTH;

  typedef logic [C_XFER_SIZE_WIDTH-1:0] cnt_t;

  fsm_state_e r_state;
  fsm_state_e w_state_nxt;
  swap_mode_e r_mode;
  cnt_t       r_beats;
  cnt_t       r_in_count;
  cnt_t       r_out_count;

  cnt_t                    w_beats_req;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_s_ready;
  logic                    w_m_valid;
  logic                    w_last_out;
  logic [1:0]              w_occ;
  logic [C_DATA_WIDTH-1:0] w_swapped;
  logic [C_DATA_WIDTH-1:0] w_fifo_data;

  // Ceiling divide as shift plus remainder flag: cannot overflow even for
  // the all-ones size, unlike (size + bytes - 1) >> log2.
  assign w_beats_req = (ctrl_xfer_size_in_bytes >> C_BYTES_LOG2)
                     + cnt_t'(|ctrl_xfer_size_in_bytes[C_BYTES_LOG2-1:0]);

  for (genvar g = 0; g < C_NUM_LANES; g++) begin : g_lane
    assign w_swapped[C_LANE_WIDTH*g +: C_LANE_WIDTH] =
      swap_lane64(s_axis_tdata[C_LANE_WIDTH*g +: C_LANE_WIDTH], r_mode);
  end

  assign w_s_ready  = (r_state == RUN) && (w_occ < 2'd2) && (r_in_count < r_beats);
  assign w_m_valid  = (w_occ != 2'd0);
  assign w_last_out = (r_out_count == r_beats - cnt_t'(1));
  assign w_push     = s_axis_tvalid & w_s_ready;
  assign w_pop      = w_m_valid & m_axis_tready;

  byteswap_skid_fifo #(
    .C_DATA_WIDTH (C_DATA_WIDTH)
  ) u_fifo (
    .ap_clk      (ap_clk),
    .areset      (areset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      (w_swapped),
    .o_data      (w_fifo_data),
    .o_occupancy (w_occ)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (ctrl_start) begin
          w_state_nxt = (ctrl_xfer_size_in_bytes == '0) ? DONE : RUN;
        end
      end
      RUN:     if (w_pop && w_last_out) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_state     <= IDLE;
      r_mode      <= PASS;
      r_beats     <= '0;
      r_in_count  <= '0;
      r_out_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && ctrl_start) begin
        r_mode      <= swap_mode_e'(ctrl_mode);
        r_beats     <= w_beats_req;
        r_in_count  <= '0;
        r_out_count <= '0;
      end else begin
        if (w_push) r_in_count  <= r_in_count + cnt_t'(1);
        if (w_pop)  r_out_count <= r_out_count + cnt_t'(1);
      end
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = w_m_valid;
  assign m_axis_tdata  = w_fifo_data;
  assign m_axis_tlast  = w_m_valid & w_last_out;
  assign ctrl_done     = (r_state == DONE);
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_byteswap_stream.sv
// Self-checking bench for byteswap_stream (W=512, size width 32).
// The reference model is a queue of expected output beats; each beat is
// produced by a byte-index permutation of the accepted input beat.
module tb_byteswap_stream;

  logic         ap_clk;
  logic         areset;
  logic         ctrl_start;
  logic [31:0]  ctrl_xfer_size_in_bytes;
  logic [1:0]   ctrl_mode;
  logic         ctrl_done;
  logic         busy;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic         m_axis_tlast;

  int tests = 0;
  int fails = 0;

  byteswap_stream #(
    .C_DATA_WIDTH      (512),
    .C_XFER_SIZE_WIDTH (32)
  ) dut (
    .ap_clk                  (ap_clk),
    .areset                  (areset),
    .ctrl_start              (ctrl_start),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .ctrl_mode               (ctrl_mode),
    .ctrl_done               (ctrl_done),
    .busy                    (busy),
    .s_axis_tvalid           (s_axis_tvalid),
    .s_axis_tready           (s_axis_tready),
    .s_axis_tdata            (s_axis_tdata),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tlast            (m_axis_tlast)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output byte i comes from input byte (i/g)*g + (g-1-i%g), g = group size.
  function automatic logic [511:0] model_swap(input logic [511:0] d, input logic [1:0] mode);
    logic [511:0] r;
    int grp;
    int src;
    grp = (mode == 2'd1) ? 4 : (mode == 2'd2) ? 8 : 1;
    for (int i = 0; i < 64; i++) begin
      src = (i / grp) * grp + (grp - 1 - i % grp);
      r[8*i +: 8] = d[8*src +: 8];
    end
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  task automatic run_xfer(input logic [31:0] size, input logic [1:0] mode,
                          input int vld_pct, input int rdy_pct, input int stall_first,
                          input bit use_pat, input logic [511:0] pat, input bit restart);
    logic [511:0] q[$];
    logic [511:0] d;
    longint beats;
    longint in_cnt;
    longint out_cnt;
    int     cyc;
    bit     fin;
    bit     sv, mr, exp_sr, exp_mv;
    beats   = (longint'(size) + 63) / 64;
    in_cnt  = 0;
    out_cnt = 0;
    cyc     = 0;
    fin     = 1'b0;
    @(negedge ap_clk);
    ctrl_start = 1'b1;
    ctrl_xfer_size_in_bytes = size;
    ctrl_mode = mode;
    @(negedge ap_clk);
    // Scramble the control inputs: they must only matter at start.
    ctrl_start = 1'b0;
    ctrl_xfer_size_in_bytes = $urandom;
    ctrl_mode = 2'($urandom);
    if (beats == 0) begin
      chk("zero_done", ctrl_done, 1'b1);
      chk("zero_busy", busy, 1'b1);
      chk("zero_s_ready", s_axis_tready, 1'b0);
      chk("zero_m_valid", m_axis_tvalid, 1'b0);
      @(negedge ap_clk);
      chk("zero_done_end", ctrl_done, 1'b0);
      chk("zero_busy_end", busy, 1'b0);
      return;
    end
    while (!fin && cyc < 2000) begin
      exp_sr = (in_cnt < beats) && (q.size() < 2);
      exp_mv = (q.size() > 0);
      chk("run_busy", busy, 1'b1);
      chk("run_done", ctrl_done, 1'b0);
      chk("s_ready", s_axis_tready, exp_sr);
      chk("m_valid", m_axis_tvalid, exp_mv);
      if (exp_mv) begin
        chk("m_data", m_axis_tdata, q[0]);
        chk("m_last", m_axis_tlast, (out_cnt == beats - 1));
      end
      sv = ($urandom_range(0, 99) < vld_pct);
      d  = use_pat ? pat : rnd512();
      mr = (cyc < stall_first) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
      s_axis_tvalid = sv;
      s_axis_tdata  = d;
      m_axis_tready = mr;
      ctrl_start    = restart && (cyc == 2);
      if (exp_mv && mr) begin
        void'(q.pop_front());
        out_cnt++;
        if (out_cnt == beats) fin = 1'b1;
      end
      if (sv && exp_sr) begin
        q.push_back(model_swap(d, mode));
        in_cnt++;
      end
      cyc++;
      @(negedge ap_clk);
    end
    ctrl_start    = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    chk("xfer_completed", fin, 1'b1);
    chk("end_done", ctrl_done, 1'b1);
    chk("end_busy", busy, 1'b1);
    chk("end_s_ready", s_axis_tready, 1'b0);
    chk("end_m_valid", m_axis_tvalid, 1'b0);
    @(negedge ap_clk);
    chk("idle_done", ctrl_done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    if (!fin) begin
      areset = 1'b1;
      @(negedge ap_clk);
      areset = 1'b0;
    end
  endtask

  initial begin
    logic [511:0] zero;
    zero = '0;
    areset = 1'b1;
    ctrl_start = 1'b0;
    ctrl_xfer_size_in_bytes = '0;
    ctrl_mode = 2'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("rst_s_ready", s_axis_tready, 1'b0);
    chk("rst_m_valid", m_axis_tvalid, 1'b0);
    chk("rst_m_last", m_axis_tlast, 1'b0);
    chk("rst_done", ctrl_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    areset = 1'b0;

    // swap32, two beats of 0x00112233 lanes
    run_xfer(32'd128, 2'd1, 100, 100, 0, 1'b1, {16{32'h00112233}}, 1'b0);
    // swap64, one beat of 0x0011223344556677 lanes
    run_xfer(32'd64, 2'd2, 100, 100, 0, 1'b1, {8{64'h0011223344556677}}, 1'b0);
    // zero-length transfer
    run_xfer(32'd0, 2'd1, 100, 100, 0, 1'b0, zero, 1'b0);
    // backpressure: downstream stalls 5 cycles on a 2-beat transfer
    run_xfer(32'd100, 2'd0, 100, 100, 5, 1'b0, zero, 1'b0);

    // reset after one accepted beat
    @(negedge ap_clk);
    ctrl_start = 1'b1;
    ctrl_xfer_size_in_bytes = 32'd128;
    ctrl_mode = 2'd1;
    @(negedge ap_clk);
    ctrl_start = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = rnd512();
    m_axis_tready = 1'b0;
    @(negedge ap_clk);
    chk("pre_rst_m_valid", m_axis_tvalid, 1'b1);
    s_axis_tvalid = 1'b0;
    areset = 1'b1;
    @(negedge ap_clk);
    chk("mid_rst_s_ready", s_axis_tready, 1'b0);
    chk("mid_rst_m_valid", m_axis_tvalid, 1'b0);
    chk("mid_rst_m_last", m_axis_tlast, 1'b0);
    chk("mid_rst_done", ctrl_done, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    areset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("post_rst_no_done", ctrl_done, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end
    run_xfer(32'd64, 2'd2, 100, 100, 0, 1'b0, zero, 1'b0);

    // second start pulse mid-run must be ignored
    run_xfer(32'd256, 2'd1, 90, 70, 0, 1'b0, zero, 1'b1);
    // reserved mode behaves as pass
    run_xfer(32'd200, 2'd3, 80, 80, 0, 1'b0, zero, 1'b0);
    // size just above one beat
    run_xfer(32'd65, 2'd2, 100, 100, 0, 1'b0, zero, 1'b0);

    for (int t = 0; t < 8; t++) begin
      run_xfer(32'($urandom_range(0, 700)), 2'($urandom_range(0, 3)),
               $urandom_range(30, 100), $urandom_range(30, 100),
               $urandom_range(0, 4), 1'b0, zero, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
